// File: rtl/hwt_pattern_driver_if.sv
// Bundle of the pattern-driver control, result and stimulus signals.
// The master modport is the driver side; the slave modport is the controller/DUT side.
interface hwt_pattern_driver_if;
  logic       start;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic       d_out;
  logic       y_in;
  logic       busy;
  logic       done;
  logic       fail;
  logic [4:0] fail_count;
  logic [3:0] first_fail_vec;

  modport master (
    input  start, y_in,
    output a_out, b_out, c_out, d_out,
    output busy, done, fail, fail_count, first_fail_vec
  );

  modport slave (
    output start, y_in,
    input  a_out, b_out, c_out, d_out,
    input  busy, done, fail, fail_count, first_fail_vec
  );
endinterface

// File: rtl/hwt_pattern_driver.sv
// Exhaustive 16-vector scan of a 4-input DUT against g = d & (c | (a & b)).
// Optional HWT_STICKY_ALARM_EN adds a sticky alarm output that only rst clears.
module hwt_pattern_driver #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  hwt_pattern_driver_if.master        bus
`ifdef HWT_STICKY_ALARM_EN
  ,
  output logic                        alarm
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [4:0] fail_count_q, fail_count_d;
  logic [3:0] first_fail_q, first_fail_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       golden;
  logic       mismatch;

  assign golden = vec_q[0] & (vec_q[1] | (vec_q[3] & vec_q[2]));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_cnt_d = settle_cnt_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    mismatch     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          vec_d        = 4'd0;
          fail_count_d = 5'd0;
          first_fail_d = 4'd0;
          state_d      = S_DRIVE;
        end
      end
      S_DRIVE: begin
        settle_cnt_d = 4'(SETTLE_CYCLES);
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        // Counter holds the SETTLE cycles still to spend, this one included.
        if (settle_cnt_q <= 4'd1) begin
          settle_cnt_d = 4'd0;
          state_d      = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        mismatch = (bus.y_in != golden);
        if (mismatch) begin
          if (fail_count_q != 5'd16) fail_count_d = fail_count_q + 5'd1;
          if (fail_count_q == 5'd0)  first_fail_d = vec_q;
        end
        if (vec_q != 4'd15) begin
          vec_d   = vec_q + 4'd1;
          state_d = S_DRIVE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // busy/done are registered decodes of the next state so they line up with the state register.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= 4'd0;
      settle_cnt_q <= 4'd0;
      fail_count_q <= 5'd0;
      first_fail_q <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_cnt_q <= settle_cnt_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.a_out          = vec_q[3];
  assign bus.b_out          = vec_q[2];
  assign bus.c_out          = vec_q[1];
  assign bus.d_out          = vec_q[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.fail           = (fail_count_q != 5'd0);
  assign bus.fail_count     = fail_count_q;
  assign bus.first_fail_vec = first_fail_q;

`ifdef HWT_STICKY_ALARM_EN
  logic alarm_q, alarm_d;

  always_comb alarm_d = alarm_q | mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_hwt_pattern_driver.sv
// Directed bench for hwt_pattern_driver: clean, stuck-at, trojan, abort and re-start scans.
// A mode-selected behavioural DUT drives y_in from the stimulus outputs.
module tb_hwt_pattern_driver;

  localparam int MODE_GOLDEN = 0;
  localparam int MODE_TIED0  = 1;
  localparam int MODE_TIED1  = 2;
  localparam int MODE_TROJAN = 3;

  logic clk;
  logic rst;
  int   mode;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;
  int   done_pulses;

  hwt_pattern_driver_if bus ();

`ifdef HWT_STICKY_ALARM_EN
  logic alarm;
  hwt_pattern_driver #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .alarm (alarm)
  );
`else
  hwt_pattern_driver #(.SETTLE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural device under test.
  always_comb begin
    logic [3:0] v;
    logic       g;
    v = {bus.a_out, bus.b_out, bus.c_out, bus.d_out};
    g = bus.d_out & (bus.c_out | (bus.a_out & bus.b_out));
    case (mode)
      MODE_TIED0:  bus.y_in = 1'b0;
      MODE_TIED1:  bus.y_in = 1'b1;
      MODE_TROJAN: bus.y_in = (v == 4'd12) ? ~g : g;
      default:     bus.y_in = g;
    endcase
  end

  always @(posedge clk) if (bus.done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One start pulse, then wait (bounded) for done; optionally re-pulse start mid-scan.
  task automatic run_scan(input string tag, input int repulse_at);
    int n;
    bit seen;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (repulse_at != 0 && n == repulse_at)     bus.start = 1'b1;
      if (repulse_at != 0 && n == repulse_at + 1) bus.start = 1'b0;
      if (n == 6 || n == 42)
        check({tag, "_vec"}, 32'({bus.a_out, bus.b_out, bus.c_out, bus.d_out}), 32'(n / 4));
      seen = (bus.done === 1'b1);
    end
    check({tag, "_done_edge"}, 32'(n), 32'd64);
    @(posedge clk); #1;
    check({tag, "_done_pulse_end"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_results(input string tag, input logic f, input logic [4:0] cnt,
                               input logic [3:0] ffv);
    check({tag, "_fail"}, 32'(bus.fail), 32'(f));
    check({tag, "_fail_count"}, 32'(bus.fail_count), 32'(cnt));
    check({tag, "_first_fail_vec"}, 32'(bus.first_fail_vec), 32'(ffv));
  endtask

  initial begin
    int snap;
    pass_cnt    = 0;
    fail_cnt    = 0;
    total_cnt   = 0;
    done_pulses = 0;
    mode        = MODE_GOLDEN;
    bus.start   = 1'b0;
    rst         = 1'b1;

    #12;
    check("rst_vec", 32'({bus.a_out, bus.b_out, bus.c_out, bus.d_out}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_results("rst", 1'b0, 5'd0, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    mode = MODE_GOLDEN;
    run_scan("golden", 0);
    check_results("golden", 1'b0, 5'd0, 4'd0);

    mode = MODE_TIED0;
    run_scan("tied0", 0);
    check_results("tied0", 1'b1, 5'd5, 4'd3);
    repeat (10) @(posedge clk);
    #1;
    check_results("tied0_hold", 1'b1, 5'd5, 4'd3);

    mode = MODE_TIED1;
    run_scan("tied1", 0);
    check_results("tied1", 1'b1, 5'd11, 4'd0);

    mode = MODE_TROJAN;
    run_scan("trojan", 0);
    check_results("trojan", 1'b1, 5'd1, 4'd12);
`ifdef HWT_STICKY_ALARM_EN
    check("trojan_alarm", 32'(alarm), 32'd1);
`endif

    mode = MODE_GOLDEN;
    run_scan("clean_after", 0);
    check_results("clean_after", 1'b0, 5'd0, 4'd0);
`ifdef HWT_STICKY_ALARM_EN
    check("alarm_sticky", 32'(alarm), 32'd1);
`endif

    // Start re-pulsed while busy must be ignored.
    mode = MODE_TIED0;
    snap = done_pulses;
    run_scan("repulse", 10);
    repeat (5) @(posedge clk);
    #1;
    check("repulse_done_count", 32'(done_pulses - snap), 32'd1);
    check_results("repulse", 1'b1, 5'd5, 4'd3);

    // Abort during vec 6 SETTLE (cycle after edge 25).
    mode = MODE_TIED0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (25) @(posedge clk);
    #3;
    check("abort_pre_vec", 32'({bus.a_out, bus.b_out, bus.c_out, bus.d_out}), 32'd6);
    check("abort_pre_count", 32'(bus.fail_count), 32'd1);
    snap = done_pulses;
    rst  = 1'b1;
    #1;
    check("abort_vec", 32'({bus.a_out, bus.b_out, bus.c_out, bus.d_out}), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check_results("abort", 1'b0, 5'd0, 4'd0);
`ifdef HWT_STICKY_ALARM_EN
    check("abort_alarm", 32'(alarm), 32'd0);
`endif
    repeat (80) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_pulses - snap), 32'd0);
    mode = MODE_GOLDEN;
    run_scan("post_abort", 0);
    check_results("post_abort", 1'b0, 5'd0, 4'd0);

    // Start held high: relaunch on the first IDLE cycle after DONE.
    bus.start = 1'b1;
    begin
      int n;
      n = 0;
      while (n < 200 && bus.done !== 1'b1) begin
        @(posedge clk); #1;
        n++;
      end
      check("held_done_edge", 32'(n), 32'd65);
    end
    @(posedge clk); #1;
    check("held_idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("held_relaunch_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
